// File: rtl/lock_display_scan.sv
// rtl/lock_display_scan.sv - 4-digit seven-segment scan driver for the lock display
// Picks per-digit glyph codes from lock/entry status and scans active-low anodes.
module lock_display_scan #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 32,
  parameter int ERR_FRAMES   = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        locked,
  input  logic        entry_active,
  input  logic [2:0]  entry_count,
  input  logic [15:0] entry_digits,
  input  logic        bad_attempt,
  output logic [4:0]  seven_in,
  output logic [3:0]  an,
  output logic        frame_tick
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int EW = $clog2(ERR_FRAMES + 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [EW-1:0] ERR_LOAD   = EW'(ERR_FRAMES);
  localparam logic [4:0]    G_BLANK    = 5'b11001;
  localparam logic [4:0]    G_DASH     = 5'b11111;

  typedef enum logic [1:0] {CLSD, ENTRY, OPEN, ERR} mode_t;

  mode_t         r_mode;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [BW-1:0] r_bcnt;
  logic          r_blink;
  logic [EW-1:0] r_err;
  logic          r_pend;
  logic [4:0]    r_seven;
  logic [3:0]    r_an;
  logic          r_tick;

  logic          w_frame_end;
  logic [2:0]    w_n;
  logic [3:0]    w_nib;
  logic [4:0]    w_glyph;
  mode_t         w_home;

  assign w_frame_end = (r_cnt == SLOT_LAST) && (r_idx == 2'd3);
  assign w_n         = (entry_count > 3'd4) ? 3'd4 : entry_count;
  assign w_home      = !locked ? OPEN : (entry_active ? ENTRY : CLSD);

  always_comb begin
    w_nib = 4'h0;
    case (r_idx)
      2'd0: w_nib = entry_digits[15:12];
      2'd1: w_nib = entry_digits[11:8];
      2'd2: w_nib = entry_digits[7:4];
      2'd3: w_nib = entry_digits[3:0];
      default: w_nib = 4'h0;
    endcase
  end

  always_comb begin
    w_glyph = G_BLANK;
    case (r_mode)
      CLSD: w_glyph = {3'b100, r_idx};
      OPEN: begin
        case (r_idx)
          2'd0: w_glyph = 5'b00000;
          2'd1: w_glyph = 5'b10111;
          2'd2: w_glyph = 5'b01110;
          default: w_glyph = 5'b11000;
        endcase
      end
      ERR: w_glyph = G_DASH;
      ENTRY: begin
        if ({1'b0, r_idx} < w_n)
          w_glyph = {1'b0, w_nib};
        else if ({1'b0, r_idx} == w_n)
          w_glyph = r_blink ? G_DASH : G_BLANK;
        else
          w_glyph = G_BLANK;
      end
      default: w_glyph = G_BLANK;
    endcase
  end

  // Mode only moves at the frame boundary so a frame never mixes two messages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode  <= CLSD;
      r_cnt   <= '0;
      r_idx   <= 2'd0;
      r_bcnt  <= '0;
      r_blink <= 1'b0;
      r_err   <= '0;
      r_pend  <= 1'b0;
      r_seven <= G_BLANK;
      r_an    <= 4'b1111;
      r_tick  <= 1'b0;
    end else begin
      r_tick  <= w_frame_end;
      r_an    <= (r_cnt == '0) ? 4'b1111 : ~(4'b1000 >> r_idx);
      r_seven <= w_glyph;
      if (r_cnt == SLOT_LAST) begin
        r_cnt <= '0;
        r_idx <= r_idx + 2'd1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_frame_end) begin
        r_pend <= bad_attempt;
        if (r_bcnt == BLINK_LAST) begin
          r_bcnt  <= '0;
          r_blink <= ~r_blink;
        end else begin
          r_bcnt <= r_bcnt + 1'b1;
        end
        if (r_pend) begin
          r_mode <= ERR;
          r_err  <= ERR_LOAD;
        end else if (r_mode == ERR && r_err > EW'(1)) begin
          r_err <= r_err - 1'b1;
        end else begin
          r_mode <= w_home;
          r_err  <= '0;
        end
      end else if (bad_attempt) begin
        r_pend <= 1'b1;
      end
    end
  end

  assign seven_in   = r_seven;
  assign an         = r_an;
  assign frame_tick = r_tick;

endmodule

// File: tb/tb_lock_display_scan.sv
// tb/tb_lock_display_scan.sv - self-checking bench for lock_display_scan
// Reference model works from the absolute cycle index and per-frame message rules.
module tb_lock_display_scan;

  localparam int R = 4;
  localparam int B = 2;
  localparam int E = 3;
  localparam int FR = 4 * R;
  localparam int MC = 0, ME = 1, MO = 2, MR = 3;
  localparam logic [19:0] CLSD_MSG = {5'h10, 5'h11, 5'h12, 5'h13};
  localparam logic [19:0] OPEN_MSG = {5'h00, 5'h17, 5'h0E, 5'h18};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        locked = 1'b1;
  logic        entry_active = 1'b0;
  logic [2:0]  entry_count = 3'd0;
  logic [15:0] entry_digits = 16'h0;
  logic        bad_attempt = 1'b0;
  logic [4:0]  seven_in;
  logic [3:0]  an;
  logic        frame_tick;

  int n_checks = 0;
  int n_fail = 0;

  int         m_k;
  int         m_mode;
  int         m_left;
  logic       m_pend;
  logic [3:0] e_an;
  logic [4:0] e_seven;
  logic       e_tick;

  lock_display_scan #(.REFRESH_DIV(R), .BLINK_FRAMES(B), .ERR_FRAMES(E)) dut (
    .clk(clk), .rst_n(rst_n), .locked(locked), .entry_active(entry_active),
    .entry_count(entry_count), .entry_digits(entry_digits), .bad_attempt(bad_attempt),
    .seven_in(seven_in), .an(an), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] ref_glyph(int mode, int k, logic [2:0] cnt, logic [15:0] dig);
    int pos, blink, n;
    pos   = (k / R) % 4;
    blink = ((k / FR) / B) % 2;
    n     = (cnt > 4) ? 4 : int'(cnt);
    if (mode == MC) return CLSD_MSG[19 - 5 * pos -: 5];
    if (mode == MO) return OPEN_MSG[19 - 5 * pos -: 5];
    if (mode == MR) return 5'h1F;
    if (pos < n) return {1'b0, dig[15 - 4 * pos -: 4]};
    if (pos == n) return (blink == 1) ? 5'h1F : 5'h19;
    return 5'h19;
  endfunction

  function automatic logic [3:0] ref_an(int k);
    logic [3:0] one_hot;
    one_hot = 4'b1000 >> ((k / R) % 4);
    return (k % R == 0) ? 4'b1111 : ~one_hot;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_k <= 0; m_mode <= MC; m_left <= 0; m_pend <= 1'b0;
      e_an <= 4'b1111; e_seven <= 5'h19; e_tick <= 1'b0;
    end else begin
      e_an    <= ref_an(m_k);
      e_seven <= ref_glyph(m_mode, m_k, entry_count, entry_digits);
      e_tick  <= (m_k % FR == FR - 1);
      if (m_k % FR == FR - 1) begin
        m_pend <= bad_attempt;
        if (m_pend) begin
          m_mode <= MR; m_left <= E;
        end else if (m_mode == MR && m_left > 1) begin
          m_left <= m_left - 1;
        end else begin
          m_mode <= !locked ? MO : (entry_active ? ME : MC);
        end
      end else if (bad_attempt) begin
        m_pend <= 1'b1;
      end
      m_k <= m_k + 1;
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; locked = 1'b1; entry_active = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (an !== 4'b1111) begin n_fail++; $display("FAIL reset_an got %b want 1111", an); end
    n_checks++;
    if (seven_in !== 5'b11001) begin n_fail++; $display("FAIL reset_seven got %b want 11001", seven_in); end
    n_checks++;
    if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick got %b want 0", frame_tick); end
    rst_n = 1'b1;
  endtask

  task automatic test_scan();
    int ticks = 0, t_first = -1, t_second = -1;
    for (int i = 1; i <= 4 * FR; i++) begin
      @(negedge clk);
      n_checks++;
      if ({an, seven_in, frame_tick} !== {e_an, e_seven, e_tick}) begin
        n_fail++;
        $display("FAIL scan k=%0d an got %b want %b seven got %b want %b tick got %b want %b",
                 m_k, an, e_an, seven_in, e_seven, frame_tick, e_tick);
      end
      if (frame_tick) begin
        ticks++;
        if (t_first < 0) t_first = i; else if (t_second < 0) t_second = i;
      end
    end
    n_checks++;
    if (ticks != 4) begin n_fail++; $display("FAIL scan_tick_count got %0d want 4", ticks); end
    n_checks++;
    if (t_second - t_first != FR) begin n_fail++; $display("FAIL scan_tick_period got %0d want %0d", t_second - t_first, FR); end
  endtask

  task automatic test_open();
    repeat (6) @(negedge clk);
    locked = 1'b0;
    for (int i = 0; i < 3 * FR; i++) begin
      @(negedge clk);
      n_checks++;
      if ({an, seven_in, frame_tick} !== {e_an, e_seven, e_tick}) begin
        n_fail++;
        $display("FAIL open k=%0d an got %b want %b seven got %b want %b tick got %b want %b",
                 m_k, an, e_an, seven_in, e_seven, frame_tick, e_tick);
      end
    end
  endtask

  task automatic test_entry();
    locked = 1'b1; entry_active = 1'b1; entry_count = 3'd2; entry_digits = 16'h7A00;
    for (int i = 0; i < 10 * FR; i++) begin
      @(negedge clk);
      n_checks++;
      if ({an, seven_in, frame_tick} !== {e_an, e_seven, e_tick}) begin
        n_fail++;
        $display("FAIL entry k=%0d an got %b want %b seven got %b want %b tick got %b want %b",
                 m_k, an, e_an, seven_in, e_seven, frame_tick, e_tick);
      end
      if (i >= 6 * FR && $urandom_range(0, 5) == 0) begin
        entry_count  = 3'($urandom_range(0, 7));
        entry_digits = 16'($urandom);
      end
    end
  endtask

  task automatic test_bad_attempt();
    int n_dash = 0, ticks = 0;
    entry_count = 3'd4; entry_digits = 16'h1234;
    while (m_k % FR != 5) @(negedge clk);
    bad_attempt = 1'b1;
    for (int i = 0; i < 8 * FR; i++) begin
      @(negedge clk);
      bad_attempt = 1'b0;
      n_checks++;
      if ({an, seven_in, frame_tick} !== {e_an, e_seven, e_tick}) begin
        n_fail++;
        $display("FAIL bad1 k=%0d an got %b want %b seven got %b want %b tick got %b want %b",
                 m_k, an, e_an, seven_in, e_seven, frame_tick, e_tick);
      end
      if (seven_in == 5'h1F) n_dash++;
    end
    n_checks++;
    if (n_dash != E * FR) begin n_fail++; $display("FAIL err_hold_cycles got %0d want %0d", n_dash, E * FR); end
    n_dash = 0;
    while (m_k % FR != 5) @(negedge clk);
    bad_attempt = 1'b1;
    for (int i = 0; i < 10 * FR; i++) begin
      @(negedge clk);
      bad_attempt = 1'b0;
      n_checks++;
      if ({an, seven_in, frame_tick} !== {e_an, e_seven, e_tick}) begin
        n_fail++;
        $display("FAIL bad2 k=%0d an got %b want %b seven got %b want %b tick got %b want %b",
                 m_k, an, e_an, seven_in, e_seven, frame_tick, e_tick);
      end
      if (seven_in == 5'h1F) n_dash++;
      if (frame_tick) ticks++;
      if (ticks == 2 && frame_tick) ticks = 100;
      else if (ticks == 100 && m_k % FR == 5) begin bad_attempt = 1'b1; ticks = 200; end
    end
    n_checks++;
    if (n_dash != (2 + E) * FR) begin n_fail++; $display("FAIL err_extend_cycles got %0d want %0d", n_dash, (2 + E) * FR); end
  endtask

  task automatic test_bad_at_tick();
    int w = 0;
    entry_active = 1'b0;
    while (!frame_tick && w < 3 * FR) begin @(negedge clk); w++; end
    n_checks++;
    if (!frame_tick) begin n_fail++; $display("FAIL tick_wait got no frame_tick want one within %0d cycles", 3 * FR); end
    bad_attempt = 1'b1;
    @(negedge clk);
    bad_attempt = 1'b0;
    n_checks++;
    if (seven_in !== 5'h10) begin n_fail++; $display("FAIL tick_same_frame got %b want 10000", seven_in); end
    w = 0;
    while (!frame_tick && w < 2 * FR) begin @(negedge clk); w++; end
    @(negedge clk);
    n_checks++;
    if (seven_in !== 5'h1F) begin n_fail++; $display("FAIL tick_err_next got %b want 11111", seven_in); end
    repeat (4 * FR) @(negedge clk);
    while (m_k % FR != FR - 1) @(negedge clk);
    bad_attempt = 1'b1;
    for (int i = 0; i < 6 * FR; i++) begin
      @(negedge clk);
      bad_attempt = 1'b0;
      n_checks++;
      if ({an, seven_in, frame_tick} !== {e_an, e_seven, e_tick}) begin
        n_fail++;
        $display("FAIL bnd_pulse k=%0d an got %b want %b seven got %b want %b tick got %b want %b",
                 m_k, an, e_an, seven_in, e_seven, frame_tick, e_tick);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60 * FR; i++) begin
      @(negedge clk);
      n_checks++;
      if ({an, seven_in, frame_tick} !== {e_an, e_seven, e_tick}) begin
        n_fail++;
        $display("FAIL random k=%0d an got %b want %b seven got %b want %b tick got %b want %b",
                 m_k, an, e_an, seven_in, e_seven, frame_tick, e_tick);
      end
      bad_attempt = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 9) == 0) begin
        locked       = ($urandom_range(0, 3) != 0);
        entry_active = $urandom_range(0, 1) == 1;
        entry_count  = 3'($urandom_range(0, 7));
        entry_digits = 16'($urandom);
      end
    end
    bad_attempt = 1'b0;
  endtask

  task automatic test_async_reset();
    locked = 1'b0; entry_active = 1'b0;
    repeat (5 * FR) @(negedge clk);
    while (m_k % R != 2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (an !== 4'b1111) begin n_fail++; $display("FAIL async_an got %b want 1111", an); end
    n_checks++;
    if (seven_in !== 5'b11001) begin n_fail++; $display("FAIL async_seven got %b want 11001", seven_in); end
    n_checks++;
    if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL async_tick got %b want 0", frame_tick); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3 * FR; i++) begin
      @(negedge clk);
      n_checks++;
      if ({an, seven_in, frame_tick} !== {e_an, e_seven, e_tick}) begin
        n_fail++;
        $display("FAIL post_reset k=%0d an got %b want %b seven got %b want %b tick got %b want %b",
                 m_k, an, e_an, seven_in, e_seven, frame_tick, e_tick);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_open();
    test_entry();
    test_bad_attempt();
    test_bad_at_tick();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lock_display_scan.md
Name: lock_display_scan

Overview:
- Time-multiplexed driver for the 4-digit seven-segment display of the VGA lock.
- Selects per-digit 5-bit glyph codes from the lock status and keypad entry, and scans the anodes.
- Feeds the 5-bit glyph decoder directly downstream.
- Shows "CLSd" when locked and idle, entered digits with a blinking cursor during code entry, "OPEn" when unlocked, and "----" for a timed period after a bad attempt.

Parameters:
- REFRESH_DIV, 100000: clock cycles per digit slot; must be >= 2.
- BLINK_FRAMES, 32: full scan frames per cursor blink half-period; must be >= 1.
- ERR_FRAMES, 128: full scan frames the error message is held; must be >= 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- locked  in  1  1 = lock closed.
- entry_active  in  1  keypad code entry in progress.
- entry_count  in  3  number of digits entered, 0..4; values >4 are treated as 4.
- entry_digits  in  16  entered nibbles; [15:12] is leftmost (position 0), [3:0] is position 3.
- bad_attempt  in  1  single-cycle pulse on a wrong code.
- seven_in  out  5  glyph code to the decoder (registered).
- an  out  4  active-low anodes; an[3] is the leftmost digit (registered).
- frame_tick  out  1  one-cycle pulse at each frame start.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: seven_in=5'b11001 (blank), an=4'b1111, frame_tick=0. Internal state: mode=CLSD, idx=0, slot counter 0, blink phase 0, error counter 0, pending-error flag 0.
- Scan counter: counts 0..REFRESH_DIV-1 and wraps. On wrap, idx advances 0→1→2→3→0.
- Frame boundary: the cycle on which idx wraps 3→0. frame_tick=1 for exactly that cycle.
- Anode drive:
  - Slot counter value 0 is a blanking cycle: an=4'b1111 (anti-ghosting).
  - Otherwise an = ~(4'b1000 >> idx).
  - an and seven_in are registered one cycle after the counter/idx state they reflect.
- Mode FSM: states CLSD, ENTRY, OPEN, ERR. Mode changes only at frame boundaries, so no frame mixes two messages.
- bad_attempt handling: the pulse sets a sticky pending-error flag. It is captured even if it coincides with a frame boundary or arrives while already in ERR.
- Transitions at a frame boundary:
  - Pending flag set: go to ERR, clear the flag, load error counter = ERR_FRAMES.
  - In ERR with error counter > 1: decrement and stay.
  - In ERR with error counter = 1: leave ERR.
  - Leaving ERR or in any non-ERR state: !locked→OPEN; locked & entry_active→ENTRY; else→CLSD.
  - A bad_attempt arriving during ERR restarts the full ERR_FRAMES hold at the next boundary.
- Glyph codes by position 0..3:
  - CLSD: 10000, 10001, 10010, 10011 ("CLSd").
  - OPEN: 00000, 10111, 01110, 11000 ("OPEn").
  - ERR: 11111 on all four positions ("----").
  - ENTRY, with n = min(entry_count,4):
    - position p < n: {1'b0, nibble p}.
    - p == n: 11111 when blink phase=1, 11001 when blink phase=0.
    - p > n: 11001.
- Blink phase: toggles every BLINK_FRAMES frame boundaries. It is free-running in all modes and is not reset on mode change.
- Entry inputs (entry_count, entry_digits) are sampled live each cycle. They are not frame-aligned; digits may update mid-frame.
- Reset mid-operation: all outputs return to reset values immediately (asynchronously). The first non-blank anode appears in the cycle after slot counter value 1.
- Widths: the slot counter is sized by $clog2(REFRESH_DIV). The frame counters are sized from BLINK_FRAMES and ERR_FRAMES. No counter overflow is permitted.

Test Plan (REFRESH_DIV=4, BLINK_FRAMES=2, ERR_FRAMES=3):
1. Reset, locked=1, entry_active=0 → an cycles 1111,0111,1011,1101,1110 pattern per 4-cycle slots; seven_in per slot 10000,10001,10010,10011; frame_tick every 16 cycles.
2. Deassert locked mid-frame → current frame still "CLSd"; next frame "OPEn": 00000,10111,01110,11000.
3. entry_active=1, entry_count=2, entry_digits=16'h7A00 → positions show 00111, 01010, then cursor alternating 11111/11001 every 2 frames, then 11001.
4. Pulse bad_attempt in ENTRY → next frame and exactly 3 frames show 11111 ×4, then back to ENTRY/CLSD per inputs; a second pulse in frame 2 of ERR extends ERR to 3 frames after its boundary.
5. bad_attempt on the same cycle as frame_tick → error captured, ERR entered at the following boundary.
6. Assert rst_n=0 mid-slot → an=1111 and seven_in=11001 asynchronously; scan restarts at idx 0 on release.
